dram_device_model: RTL

DRAM_DEVICE_MODEL -- requirements
Module: dram_device_model

---
 rtl/dram_device_model.sv | 82 ++++++++
 1 files changed

// File: rtl/dram_device_model.sv
// dram_device_model: single-bank DRAM behavioural model with t_RCD checking, byte writes and CAS-latency read pipeline
module dram_device_model #(
  parameter int CAS_LAT = 5,
  parameter int T_RCD   = 5,
  parameter int MEM_AW  = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        DRAM_CSn,
  input  logic        DRAM_RASn,
  input  logic        DRAM_CASn,
  input  logic [3:0]  DRAM_WEn,
  input  logic [10:0] DRAM_A,
  input  logic [31:0] DRAM_D,
  output logic [31:0] DRAM_Q,
  output logic        DRAM_valid,
  output logic        DRAM_err
);
  localparam int CW = $clog2(T_RCD + 2);
  localparam logic [CW-1:0] RCD = CW'(T_RCD);
  typedef enum logic {IDLE, OPEN} state_t;
  state_t state;
  logic [10:0] row;
  logic [CW-1:0] cnt;
  logic [31:0] mem [0:2**MEM_AW-1];
  logic vld_p [CAS_LAT];
  logic [31:0] dat_p [CAS_LAT];
  logic ras, cas, act, pre, rd, wr, is_open, cas_ok, viol, act_ok, pre_ok, rd_ok, wr_ok;
  logic [MEM_AW-1:0] idx;
  assign ras = !DRAM_CSn && !DRAM_RASn;
  assign cas = !DRAM_CSn && !DRAM_CASn;
  assign act = ras && !cas && DRAM_WEn == 4'hF;
  assign pre = ras && !cas && DRAM_WEn == 4'h0;
  assign rd = cas && !ras && DRAM_WEn == 4'hF;
  assign wr = cas && !ras && DRAM_WEn != 4'hF;
  assign is_open = state == OPEN;
  assign cas_ok = is_open && cnt == RCD;
  assign viol = (act && is_open) || (pre && !is_open) || ((rd || wr) && !cas_ok) || (ras && cas);
  assign act_ok = act && !is_open;
  assign pre_ok = pre && is_open;
  assign rd_ok = rst_n && rd && cas_ok;
  assign wr_ok = rst_n && wr && cas_ok;
  assign idx = MEM_AW'({row, DRAM_A[9:0]});
  assign DRAM_valid = vld_p[CAS_LAT-1];
  assign DRAM_Q = dat_p[CAS_LAT-1];
  // Row state machine, activate-to-CAS counter and sticky protocol error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      row <= '0;
      cnt <= '0;
      DRAM_err <= 1'b0;
    end else begin
      if (act_ok) begin
        state <= OPEN;
        row <= DRAM_A;
      end else if (pre_ok) state <= IDLE;
      cnt <= act_ok ? '0 : (cnt == RCD ? cnt : cnt + 1'b1);
      if (viol) DRAM_err <= 1'b1;
    end
  end
  // Byte-masked array write; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ok)
      for (int i = 0; i < 4; i++)
        if (!DRAM_WEn[i]) mem[idx][8*i +: 8] <= DRAM_D[8*i +: 8];
  end
  // Read pipeline: word captured at issue, zero data carried with invalid slots
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p <= '{default: 1'b0};
      dat_p <= '{default: 32'h0};
    end else begin
      vld_p[0] <= rd_ok;
      dat_p[0] <= rd_ok ? mem[idx] : 32'h0;
      for (int i = 1; i < CAS_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        dat_p[i] <= dat_p[i-1];
      end
    end
  end
endmodule
